// File: rtl/seg7_scan_ctrl_pkg.sv
// Shared definitions for the 8-digit 7-segment scan controller: FSM state
// encoding, digit/port widths, segment code table and the hex decode helper.
// Used by seg7_scan_ctrl, seg7_decode and the write-port interface.
package seg7_pkg;

    localparam logic ST_GUARD = 1'b0;
    localparam logic ST_DRIVE = 1'b1;

    typedef enum logic {
        GUARD = ST_GUARD,
        DRIVE = ST_DRIVE
    } state_t;

    localparam int NUM_DIGITS = 8;
    localparam int DIGIT_AW   = 3;
    localparam int DIGIT_DW   = 5;   // {dp, hex[3:0]}

    // Active-low segment patterns {dp,g,f,e,d,c,b,a} for hex 0..F, dp off.
    localparam logic [7:0] SEG_CODES [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    // Look up the segment pattern and pull the dp segment low when requested.
    function automatic logic [7:0] hex2seg(input logic dp, input logic [3:0] hex);
        logic [7:0] code;
        code = SEG_CODES[hex];
        if (dp) begin
            code[7] = 1'b0;
        end
        return code;
    endfunction

endpackage

// File: rtl/seg7_scan_ctrl_if.sv
// Digit write port of the scan controller. The master writes one digit per
// wr_en cycle; the controller (slave) always accepts, there is no handshake.
interface seg7_scan_ctrl_if;
    import seg7_pkg::*;

    logic                wr_en;
    logic [DIGIT_AW-1:0] wr_addr;
    logic [DIGIT_DW-1:0] wr_data;

    modport master (output wr_en, output wr_addr, output wr_data);
    modport slave  (input  wr_en, input  wr_addr, input  wr_data);

endinterface

// File: rtl/seg7_scan_ctrl_decode.sv
// seg7_decode: purely combinational {dp, hex} -> active-low segment bus.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic       dp,
    input  logic [3:0] hex,
    output logic [7:0] seg
);

    assign seg = hex2seg(dp, hex);

endmodule

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: time-multiplexed scan controller for an 8-digit
// common-anode 7-segment display. Each digit slot is SLOT_CYCLES long and
// starts with GUARD_CYCLES of all-dark outputs to avoid ghosting. The value
// shown in a slot is a shadow copy taken on the last guard cycle, so writes
// never tear a slot that is being driven.
// Optional feature: define SEG_DIM_EN to add the bright[2:0] input, which
// splits DRIVE into 8 sub-phases and lights the digit for sub-phases 0..bright.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int SLOT_CYCLES  = 50000,
    parameter int GUARD_CYCLES = 500,
    parameter int CNT_W        = 16
) (
    input  logic                clk,
    input  logic                rst,          // asynchronous, active low
    seg7_scan_ctrl_if.slave     wr,
    input  logic [7:0]          blank_mask,
`ifdef SEG_DIM_EN
    input  logic [2:0]          bright,
`endif
    output logic [7:0]          c,
    output logic [7:0]          en,
    output logic                frame_tick
);

    localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_CYCLES - 1);
    localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(SLOT_CYCLES - 1);
    localparam logic [DIGIT_AW-1:0] LAST_IDX = DIGIT_AW'(NUM_DIGITS - 1);

    // Digit storage and scan state
    logic [DIGIT_DW-1:0] digit_reg [NUM_DIGITS];
    logic [DIGIT_DW-1:0] shadow_reg;
    state_t              state_reg, state_next;
    logic [CNT_W-1:0]    cnt_reg, cnt_next;
    logic [DIGIT_AW-1:0] idx_reg, idx_next;
    logic                guard_end;
    logic                slot_end;

    // Output path
    logic [7:0]          seg_code;
    logic                lit;
    logic                dim_on;
    logic [7:0]          c_next;
    logic [7:0]          en_next;
    logic [7:0]          c_reg;
    logic [7:0]          en_reg;
    logic                frame_tick_reg;

    // Digit register file: one digit per write strobe, always accepted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                digit_reg[i] <= '0;
            end
        end else if (wr.wr_en) begin
            digit_reg[wr.wr_addr] <= wr.wr_data;
        end
    end

    // Shadow copy of the scanned digit, taken on the last guard cycle. A write
    // landing on the same edge is not seen here until that digit's next slot.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shadow_reg <= '0;
        end else if (guard_end) begin
            shadow_reg <= digit_reg[idx_reg];
        end
    end

    // Scan FSM state register: state, slot counter and digit index.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= GUARD;
            cnt_reg   <= '0;
            idx_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            idx_reg   <= idx_next;
        end
    end

    // Scan FSM next state: counter runs every cycle and clears only at slot end.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg + CNT_W'(1);
        idx_next   = idx_reg;
        guard_end  = 1'b0;
        slot_end   = 1'b0;
        case (state_reg)
            GUARD: begin
                if (cnt_reg == GUARD_LAST) begin
                    guard_end  = 1'b1;
                    state_next = DRIVE;
                end
            end
            DRIVE: begin
                if (cnt_reg == SLOT_LAST) begin
                    slot_end   = 1'b1;
                    cnt_next   = '0;
                    idx_next   = idx_reg + DIGIT_AW'(1);
                    state_next = GUARD;
                end
            end
            default: begin
                state_next = GUARD;
            end
        endcase
    end

`ifdef SEG_DIM_EN
    localparam int SUB_RAW = (SLOT_CYCLES - GUARD_CYCLES) / 8;
    localparam int SUB_LEN = (SUB_RAW < 1) ? 1 : SUB_RAW;
    localparam logic [CNT_W-1:0] SUB_LAST = CNT_W'(SUB_LEN - 1);

    logic [CNT_W-1:0] sub_cnt_reg;
    logic [2:0]       sub_idx_reg;
    logic [2:0]       bright_reg;

    // Sub-phase tracker for dimming; the last sub-phase absorbs any remainder
    // because the index stops advancing once it reaches 7.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sub_cnt_reg <= '0;
            sub_idx_reg <= '0;
            bright_reg  <= '0;
        end else if (guard_end) begin
            sub_cnt_reg <= '0;
            sub_idx_reg <= '0;
            bright_reg  <= bright;
        end else if (state_reg == DRIVE && sub_idx_reg != 3'd7) begin
            if (sub_cnt_reg == SUB_LAST) begin
                sub_cnt_reg <= '0;
                sub_idx_reg <= sub_idx_reg + 3'd1;
            end else begin
                sub_cnt_reg <= sub_cnt_reg + CNT_W'(1);
            end
        end
    end

    assign dim_on = (sub_idx_reg <= bright_reg);
`else
    assign dim_on = 1'b1;
`endif

    seg7_decode u_decode (
        .dp  (shadow_reg[4]),
        .hex (shadow_reg[3:0]),
        .seg (seg_code)
    );

    // Output selection: dark during guard, decoded shadow during drive;
    // a blanked digit keeps its enable high for the whole slot.
    always_comb begin
        c_next = 8'hFF;
        lit    = 1'b0;
        if (state_reg == DRIVE) begin
            c_next = seg_code;
            lit    = !blank_mask[idx_reg] && dim_on;
        end
    end

    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_en
        assign en_next[gi] = ~(lit && (idx_reg == DIGIT_AW'(gi)));
    end

    // Registered outputs; async reset forces the display dark immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            c_reg          <= 8'hFF;
            en_reg         <= 8'hFF;
            frame_tick_reg <= 1'b0;
        end else begin
            c_reg          <= c_next;
            en_reg         <= en_next;
            frame_tick_reg <= slot_end && (idx_reg == LAST_IDX);
        end
    end

    assign c          = c_reg;
    assign en         = en_reg;
    assign frame_tick = frame_tick_reg;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Self-checking bench for seg7_scan_ctrl with SLOT_CYCLES=16, GUARD_CYCLES=2.
// Table-driven slot checks plus directed sequences for write timing,
// blanking, frame_tick spacing and mid-slot reset.
module tb_seg7_scan_ctrl;

    localparam int SLOT  = 16;
    localparam int GUARD = 2;
    localparam int DRIVE_LEN = SLOT - GUARD;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] blank_mask = 8'h00;
    logic [7:0] c;
    logic [7:0] en;
    logic       frame_tick;
`ifdef SEG_DIM_EN
    logic [2:0] bright = 3'd7;
`endif

    seg7_scan_ctrl_if wr_if ();

    seg7_scan_ctrl #(
        .SLOT_CYCLES  (SLOT),
        .GUARD_CYCLES (GUARD),
        .CNT_W        (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wr         (wr_if),
        .blank_mask (blank_mask),
`ifdef SEG_DIM_EN
        .bright     (bright),
`endif
        .c          (c),
        .en         (en),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int total_cnt = 0;

    typedef struct {
        logic [4:0] data;
        logic [7:0] exp_en;
        logic [7:0] exp_c;
    } vec_t;

    vec_t vecs [16];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            pass_cnt++;
        end
    endtask

    task automatic write_digit(input logic [2:0] addr, input logic [4:0] data);
        wr_if.wr_en   = 1'b1;
        wr_if.wr_addr = addr;
        wr_if.wr_data = data;
        step();
        wr_if.wr_en   = 1'b0;
        $display("write digit %0d data %h", addr, data);
    endtask

    task automatic wait_tick(input int budget);
        int n;
        n = 0;
        while (frame_tick !== 1'b1 && n < budget) begin
            step();
            n++;
        end
        check("wait_tick_timeout", (n >= budget), 0);
    endtask

    task automatic wait_en(input logic [7:0] target, input int budget);
        int n;
        n = 0;
        while (en !== target && n < budget) begin
            step();
            n++;
        end
        check("wait_en_timeout", (n >= budget), 0);
    endtask

    // Measure the dark gap before the next lit slot, then the slot itself.
    task automatic capture(output logic [7:0] s_en, output logic [7:0] s_c,
                           output int len, output int gap);
        gap = 0;
        while (en === 8'hFF && gap < 200) begin
            gap++;
            step();
        end
        s_en = en;
        s_c  = c;
        len  = 0;
        while (en === s_en && c === s_c && len < 200) begin
            len++;
            step();
        end
        $display("slot en=%h c=%h len=%0d gap=%0d", s_en, s_c, len, gap);
    endtask

    initial begin
        logic [7:0] s_en;
        logic [7:0] s_c;
        int         len;
        int         gap;
        int         ticks;
        int         tick_pos [2];

        // Frame 1: digits 0..7; frame 2: digits 8..F with dp on B and E.
        vecs[0]  = '{5'h00, 8'hFE, 8'hC0};
        vecs[1]  = '{5'h01, 8'hFD, 8'hF9};
        vecs[2]  = '{5'h02, 8'hFB, 8'hA4};
        vecs[3]  = '{5'h03, 8'hF7, 8'hB0};
        vecs[4]  = '{5'h04, 8'hEF, 8'h99};
        vecs[5]  = '{5'h05, 8'hDF, 8'h92};
        vecs[6]  = '{5'h06, 8'hBF, 8'h82};
        vecs[7]  = '{5'h07, 8'h7F, 8'hF8};
        vecs[8]  = '{5'h08, 8'hFE, 8'h80};
        vecs[9]  = '{5'h09, 8'hFD, 8'h90};
        vecs[10] = '{5'h0A, 8'hFB, 8'h88};
        vecs[11] = '{5'h1B, 8'hF7, 8'h03};
        vecs[12] = '{5'h0C, 8'hEF, 8'hC6};
        vecs[13] = '{5'h0D, 8'hDF, 8'hA1};
        vecs[14] = '{5'h1E, 8'hBF, 8'h06};
        vecs[15] = '{5'h0F, 8'h7F, 8'h8E};

        wr_if.wr_en   = 1'b0;
        wr_if.wr_addr = 3'd0;
        wr_if.wr_data = 5'd0;
        rst = 1'b0;
        repeat (3) step();
        check("reset_c", c, 8'hFF);
        check("reset_en", en, 8'hFF);
        check("reset_tick", frame_tick, 1'b0);
        rst = 1'b1;

        // Two table-driven frames
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < 8; i++) begin
                write_digit(3'(i), vecs[f*8+i].data);
            end
            wait_tick(400);
            step();
            for (int i = 0; i < 8; i++) begin
                capture(s_en, s_c, len, gap);
                check("scan_en", s_en, vecs[f*8+i].exp_en);
                check("scan_c", s_c, vecs[f*8+i].exp_c);
                check("scan_len", len, DRIVE_LEN);
                check("scan_gap", gap, GUARD);
            end
        end

        // Write to digit 3 while it is driven: old value for the whole slot
        write_digit(3'd3, 5'h03);
        wait_en(8'hF7, 200);
        check("tear_first_c", c, 8'hB0);
        len = 1;
        wr_if.wr_en   = 1'b1;
        wr_if.wr_addr = 3'd3;
        wr_if.wr_data = 5'h1A;
        step();
        wr_if.wr_en   = 1'b0;
        $display("write digit 3 data 1a during drive");
        while (en === 8'hF7 && c === 8'hB0 && len < 200) begin
            len++;
            step();
        end
        check("tear_old_len", len, DRIVE_LEN);
        wait_en(8'hFF, 50);
        wait_en(8'hF7, 200);
        check("tear_new_c", c, 8'h08);

        // Blank digit 2 for a full frame
        blank_mask = 8'h04;
        wait_tick(300);
        step();
        for (int j = 0; j < 7; j++) begin
            int i;
            logic [7:0] exp_c;
            i = (j < 2) ? j : j + 1;
            exp_c = (i == 3) ? 8'h08 : vecs[8+i].exp_c;
            capture(s_en, s_c, len, gap);
            check("blank_en", s_en, vecs[8+i].exp_en);
            check("blank_c", s_c, exp_c);
            check("blank_len", len, DRIVE_LEN);
            check("blank_gap", gap, (i == 3) ? GUARD + SLOT : GUARD);
        end
        blank_mask = 8'h00;

        // frame_tick spacing over two frames
        wait_tick(400);
        check("tick_en", en, 8'h7F);
        ticks = 0;
        tick_pos[0] = 0;
        tick_pos[1] = 0;
        for (int k = 1; k <= 256; k++) begin
            step();
            if (frame_tick === 1'b1) begin
                if (ticks < 2) tick_pos[ticks] = k;
                ticks++;
            end
        end
        $display("frame ticks %0d at %0d and %0d", ticks, tick_pos[0], tick_pos[1]);
        check("tick_count", ticks, 2);
        check("tick_pos0", tick_pos[0], 128);
        check("tick_pos1", tick_pos[1], 256);

        // Reset in the middle of digit 5's drive
        wait_en(8'hDF, 300);
        step();
        step();
        rst = 1'b0;
        #1;
        check("midrst_c", c, 8'hFF);
        check("midrst_en", en, 8'hFF);
        check("midrst_tick", frame_tick, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        capture(s_en, s_c, len, gap);
        check("postrst_en", s_en, 8'hFE);
        check("postrst_c", s_c, 8'hC0);
        check("postrst_len", len, DRIVE_LEN);
        capture(s_en, s_c, len, gap);
        check("postrst_d1_en", s_en, 8'hFD);
        check("postrst_d1_c", s_c, 8'hC0);
        check("postrst_d1_gap", gap, GUARD);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

endmodule
